// File: rtl/sram_bank.sv
// Single-port synchronous SRAM bank with valid/ready requests, byte strobes,
// 1- or 2-cycle read latency and an optional zero-fill sequence after reset.
module sram_bank #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned DEPTH          = 262144,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [XLEN-1:0]          req_wdata,
    input  logic [XLEN/8-1:0]        req_wstrb,
    output logic                     rsp_valid,
    output logic [XLEN-1:0]          rsp_rdata,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = XLEN / 8;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_bank: READ_LATENCY must be 1 or 2");
    end
    if (XLEN % 8 != 0) begin : g_bad_xlen
        $error("sram_bank: XLEN must be a multiple of 8");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_addr;
    logic [XLEN-1:0] mem [DEPTH];

    logic            in_range_c;
    logic            accept_c;
    logic            rd_accept_c;
    logic            wr_en_c;
    logic [AW-1:0]   wr_addr_c;
    logic [XLEN-1:0] wr_data_c;
    logic [NB-1:0]   wr_strb_c;
    logic [XLEN-1:0] rd_word_c;

    // Address range check only exists when DEPTH leaves holes in the address space.
    if ((2 ** AW) == DEPTH) begin : g_pow2
        assign in_range_c = 1'b1;
    end else begin : g_npow2
        assign in_range_c = (32'(req_addr) < DEPTH);
    end

    // Shared write port: the clear sequencer owns it while clearing.
    always_comb begin
        accept_c    = req_valid && req_ready && !rst;
        rd_accept_c = accept_c && !req_we;
        wr_en_c     = 1'b0;
        wr_addr_c   = req_addr;
        wr_data_c   = req_wdata;
        wr_strb_c   = req_wstrb;
        rd_word_c   = '0;
        if (state == ST_CLEAR) begin
            wr_en_c   = !rst;
            wr_addr_c = clr_addr;
            wr_data_c = '0;
            wr_strb_c = '1;
        end else if (accept_c && req_we && in_range_c) begin
            wr_en_c = 1'b1;
        end
        if (rd_accept_c && in_range_c) begin
            rd_word_c = mem[req_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wr_strb_c[i]) begin
                    mem[wr_addr_c][8*i +: 8] <= wr_data_c[8*i +: 8];
                end
            end
        end
    end

    // Clear sequencer: one zero word per cycle, then open the request port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_addr  <= '0;
            busy      <= (CLEAR_ON_RESET != 0);
            req_ready <= (CLEAR_ON_RESET == 0);
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == AW'(DEPTH - 1)) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    if (READ_LATENCY == 2) begin : g_rl2
        logic            s1_valid;
        logic [XLEN-1:0] s1_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_valid  <= 1'b0;
                s1_data   <= '0;
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
            end else begin
                s1_valid  <= rd_accept_c;
                rsp_valid <= s1_valid;
                if (rd_accept_c) begin
                    s1_data <= rd_word_c;
                end
                if (s1_valid) begin
                    rsp_rdata <= s1_data;
                end
            end
        end
    end else begin : g_rl1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
            end else begin
                rsp_valid <= rd_accept_c;
                if (rd_accept_c) begin
                    rsp_rdata <= rd_word_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bank.sv
// Bench for sram_bank: two instances (latency 1 without clear, latency 2 with
// clear, both DEPTH=12) share one request stream and are checked against a model.
module tb_sram_bank;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 12;
    localparam int          RL0   = 1;
    localparam int          RL1   = 2;

    typedef struct {
        int          due;
        logic [63:0] data;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;

    logic        ready_a [2];
    logic        rsp_valid_a [2];
    logic [63:0] rsp_rdata_a [2];
    logic        busy_a [2];

    int          n_assert;
    int          n_fail;
    int          cyc;
    logic [63:0] mdl [2][DEPTH];
    int          clr_cnt [2];
    logic [63:0] last [2];
    rsp_t        pq [2][$];

    sram_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .READ_LATENCY(RL0), .CLEAR_ON_RESET(0)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid_a[0]), .rsp_rdata(rsp_rdata_a[0]), .busy(busy_a[0])
    );

    sram_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .READ_LATENCY(RL1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid_a[1]), .rsp_rdata(rsp_rdata_a[1]), .busy(busy_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic exp_v;
            exp_v = 1'b0;
            if (pq[i].size() > 0 && pq[i][0].due == cyc) begin
                exp_v   = 1'b1;
                last[i] = pq[i][0].data;
                void'(pq[i].pop_front());
            end
            chk($sformatf("u%0d_rsp_valid@%0d", i, cyc), 64'(rsp_valid_a[i]), 64'(exp_v));
            chk($sformatf("u%0d_rsp_rdata@%0d", i, cyc), rsp_rdata_a[i], last[i]);
            chk($sformatf("u%0d_busy@%0d", i, cyc), 64'(busy_a[i]), 64'(clr_cnt[i] != 0));
            chk($sformatf("u%0d_ready@%0d", i, cyc), 64'(ready_a[i]), 64'(clr_cnt[i] == 0));
        end
    endtask

    // One clock: drive a request, advance the model by one edge, compare.
    task automatic step(input logic v, input logic we, input logic [3:0] a,
                        input logic [63:0] d, input logic [7:0] s);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (clr_cnt[i] > 0) begin
                    mdl[i][DEPTH - clr_cnt[i]] = '0;
                    clr_cnt[i]--;
                end else if (v) begin
                    if (we) begin
                        if (a < 4'd12) begin
                            for (int b = 0; b < 8; b++) begin
                                if (s[b]) mdl[i][a][8*b +: 8] = d[8*b +: 8];
                            end
                        end
                    end else begin
                        rsp_t r;
                        r.due  = cyc + ((i == 0) ? RL0 : RL1) - 1;
                        r.data = (a < 4'd12) ? mdl[i][a] : 64'd0;
                        pq[i].push_back(r);
                    end
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 64'd0, 8'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b0, a, 64'd0, 8'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] s);
        step(1'b1, 1'b1, a, d, s);
    endtask

    // Asynchronous reset asserted between edges, held for `hold` edges.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pq[i].delete();
            last[i]    = '0;
            clr_cnt[i] = (i == 1) ? int'(DEPTH) : 0;
        end
        #1;
        check_outputs();
        idle(hold);
        #2 rst = 1'b0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        #1;
        do_reset(2);

        // Initial clear of u1, then preload both banks with nonzero data.
        idle(DEPTH);
        for (int a = 0; a < int'(DEPTH); a++) wr(4'(a), {$urandom, $urandom} | 64'h1, 8'hFF);

        // Latency: write then read next cycle.
        wr(4'd3, 64'h0123456789ABCDEF, 8'hFF);
        rd(4'd3);
        chk("lat1_valid", 64'(rsp_valid_a[0]), 64'd1);
        chk("lat1_data", rsp_rdata_a[0], 64'h0123456789ABCDEF);
        chk("lat2_not_yet", 64'(rsp_valid_a[1]), 64'd0);
        idle(1);
        chk("lat2_valid", 64'(rsp_valid_a[1]), 64'd1);
        chk("lat2_data", rsp_rdata_a[1], 64'h0123456789ABCDEF);
        chk("lat1_pulse_end", 64'(rsp_valid_a[0]), 64'd0);
        idle(1);

        // Byte strobes and zero-strobe no-op.
        wr(4'd5, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        wr(4'd5, 64'h0000000000000000, 8'h0F);
        wr(4'd5, 64'h123456789ABCDEF0, 8'h00);
        rd(4'd5);
        chk("strb_data", rsp_rdata_a[0], 64'hFFFFFFFF00000000);
        idle(2);

        // Back-to-back reads through the 2-stage pipeline.
        for (int a = 0; a < 4; a++) wr(4'(a), 64'(10 + a), 8'hFF);
        for (int a = 0; a < 4; a++) begin
            rd(4'(a));
            if (a > 0) chk($sformatf("b2b_%0d", a - 1), rsp_rdata_a[1], 64'(10 + a - 1));
        end
        idle(1);
        chk("b2b_3", rsp_rdata_a[1], 64'd13);
        chk("b2b_3_valid", 64'(rsp_valid_a[1]), 64'd1);
        idle(2);

        // Out of range write ignored, read returns zero on time.
        wr(4'd13, 64'hAA, 8'hFF);
        rd(4'd13);
        chk("oor_valid", 64'(rsp_valid_a[0]), 64'd1);
        chk("oor_data", rsp_rdata_a[0], 64'd0);
        idle(2);
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(3);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] s;
            s = 8'($urandom);
            if ($urandom_range(0, 7) == 0) s = 8'd0;
            step(($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom}, s);
        end
        idle(3);

        // Clear on reset: exactly DEPTH busy cycles, then u1 reads all zero.
        do_reset(2);
        idle(DEPTH - 1);
        chk("clr_busy_last", 64'(busy_a[1]), 64'd1);
        idle(1);
        chk("clr_done_busy", 64'(busy_a[1]), 64'd0);
        chk("clr_done_ready", 64'(ready_a[1]), 64'd1);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            if (a >= 1 && a <= 12) chk($sformatf("clr_zero_%0d", a - 1), rsp_rdata_a[1], 64'd0);
        end
        idle(3);

        // Reset again at clear cycle 7: clear restarts from address 0.
        for (int a = 0; a < int'(DEPTH); a++) wr(4'(a), 64'hDEAD0000 + 64'(a), 8'hFF);
        do_reset(1);
        idle(7);
        do_reset(1);
        idle(DEPTH - 1);
        chk("restart_busy_last", 64'(busy_a[1]), 64'd1);
        idle(1);
        chk("restart_done", 64'(busy_a[1]), 64'd0);
        for (int a = 0; a < int'(DEPTH); a++) rd(4'(a));
        idle(3);

        // Reset during an in-flight read drops it.
        rd(4'd2);
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk($sformatf("rst_drop_v_%0d", k), 64'(rsp_valid_a[1]), 64'd0);
            chk($sformatf("rst_drop_d_%0d", k), rsp_rdata_a[1], 64'd0);
        end
        idle(DEPTH);
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 9) < 8), 1'($urandom), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom}, 8'($urandom));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
